uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
Transmit scheduler that shares the single UART send engine between NUM_REQ byte producers, e.g. the CPU bus write path and a debug/trace source. Round-robin arbitration with packet locking. Each accepted byte is sequenced into the send engine by pulsing its enable, waiting for busy to rise, then waiting for busy to fall. Sits between the producers and the uart_send instance inside the UART peripheral.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ID_W, 1, width of grant_id; equals ceil(log2(NUM_REQ)), minimum 1
BUSY_TIMEOUT, 64, max cycles in WAIT_START before abort (used only with the macro)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  NUM_REQ*8  per-requester byte; requester i uses bits [8i+7:8i]
req_last  input  NUM_REQ  byte is the last of its packet
req_ready  output  NUM_REQ  byte accepted this cycle when valid & ready
tx_en  output  1  enable pulse to the send engine
tx_data  output  8  byte to the send engine
tx_busy  input  1  send engine busy
grant_id  output  ID_W  current/last granted requester
active  output  1  packet lock held
err_timeout  output  1  one-cycle pulse on busy timeout

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=SELECT, req_ready=0, tx_en=0, tx_data=0, grant_id=0, active=0, err_timeout=0. The round-robin pointer resets so that requester 0 has highest priority first.
- States:
  - SELECT: no lock. Pick the first valid requester starting at (last_grant+1) mod NUM_REQ, wrapping. If none is valid, stay. In the choosing cycle, req_ready[g]=1 combinationally and the byte is accepted. Set grant_id=g and last_grant=g. active=1 unless req_last[g]. Go to LOAD.
  - LOCKED: lock held. req_ready[grant_id]=1; all other ready bits=0. Other requesters are ignored even if valid. On accept, go to LOAD; active clears if req_last. If valid is low, wait indefinitely.
  - LOAD: tx_en=1 for exactly one cycle. Go to WAIT_START.
  - WAIT_START: wait for tx_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for tx_busy=0. Then go to LOCKED if active, else SELECT.
- req_ready is high only in SELECT/LOCKED, for at most one requester. Every other state drives all zeros.
- tx_data is registered on accept and holds stable until the next accept.
- Latency: accept at cycle N, tx_en high at N+1. Next accept is no earlier than the cycle tx_busy is seen low in WAIT_DONE + 1.
- Simultaneous valid in SELECT: round-robin order only; the lock is granted to one requester.
- tx_busy already high on entry to WAIT_START is treated as the start.
- Reset mid-operation aborts immediately. Any partial packet is dropped; the producer must resend.
- req_last on a single-byte packet: active never asserts.

Optional Feature:
UART_TX_SCHED_TIMEOUT_EN
- With the macro: a counter runs in WAIT_START. If tx_busy has not risen after BUSY_TIMEOUT cycles:
  - err_timeout pulses for 1 cycle.
  - active clears, releasing the lock.
  - State goes to SELECT; the byte is dropped.
  - The counter clears on leaving WAIT_START.
- Without the macro: WAIT_START waits forever, err_timeout is tied 0, and no counter logic is built.

Decomposition:
- Shared package:
  - State encoding constants (SELECT, LOCKED, LOAD, WAIT_START, WAIT_DONE; 3 bits).
  - Byte width constant 8.
  - Default BUSY_TIMEOUT.
- One sub-module, rr_arbiter:
  - Inputs: request vector, last-grant pointer.
  - Outputs: one-hot grant and encoded id.
  - Purely combinational.
- All sequencing lives in uart_tx_sched.

Test Plan:
- Reset/idle: hold rst_n=0 with req_valid=2'b11 -> all outputs 0. After release, requester 0 is granted first: grant_id=0, tx_data=req_data[7:0].
- Single byte: req 1 sends 8'hA5 with last=1; busy model raises 2 cycles after tx_en and holds 20 cycles -> one tx_en pulse, tx_data=8'hA5, active=0, back to SELECT.
- Packet lock: req 0 sends 3 bytes 8'h11/22/33 (last on 33) while req 1 holds valid with 8'h99 -> sequence on tx_data is 11,22,33,99. req_ready[1]=0 until 33 completes.
- Round robin: both requesters stream single-byte packets, 4 each -> grants alternate 0,1,0,1...
- Mid-op reset: assert rst_n=0 during WAIT_DONE -> outputs return to reset values asynchronously, with no further tx_en.
- Timeout (macro on, BUSY_TIMEOUT=64): tx_busy held 0 -> err_timeout pulses once, 64 cycles after entering WAIT_START. Lock released; next byte is accepted. With the macro off -> stalls, err_timeout stays 0.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sched_pkg
// Description : Shared types and constants for the UART transmit scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_sched_pkg;

  // Scheduler sequencing states, 3-bit encoding
  typedef enum logic [2:0] {
    S_SELECT     = 3'd0,
    S_LOCKED     = 3'd1,
    S_LOAD       = 3'd2,
    S_WAIT_START = 3'd3,
    S_WAIT_DONE  = 3'd4
  } state_t;

  // Width of one transmitted byte
  localparam int c_byte_w = 8;

  // Default number of WAIT_START cycles before the busy-timeout abort
  localparam int c_default_busy_timeout = 64;

endpackage
`default_nettype wire

// File: rtl/uart_tx_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sched_rr_arbiter
// Description : Combinational round-robin arbiter. The search starts at the
//               requester after last_grant and wraps; the first valid request
//               wins. Produces a one-hot grant and its encoded index.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               found
);

  int w_dist;
  int w_best;

  // Pick the valid requester with the smallest circular distance past last_grant
  always_comb begin
    w_best   = NUM_REQ;
    w_dist   = 0;
    grant_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = i - int'(last_grant) - 1;
      if (w_dist < 0) begin
        w_dist = w_dist + NUM_REQ;
      end
      if (req[i] && (w_dist < w_best)) begin
        w_best   = w_dist;
        grant_id = ID_W'(i);
      end
    end
    found = (w_best < NUM_REQ);
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = found && (grant_id == ID_W'(i));
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sched
// Description : Shares one UART send engine between NUM_REQ byte producers.
//               Round-robin selection with packet locking; each accepted byte
//               is sequenced as enable pulse -> busy rise -> busy fall.
//               Optional busy-start timeout under UART_TX_SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int ID_W         = 1,
  parameter int BUSY_TIMEOUT = c_default_busy_timeout
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*c_byte_w-1:0] req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_en,
  output logic [c_byte_w-1:0]         tx_data,
  input  logic                        tx_busy,
  output logic [ID_W-1:0]             grant_id,
  output logic                        active,
  output logic                        err_timeout
);

  // The pointer resets to the top requester so requester 0 wins first;
  // grant_id itself resets to 0, hence a separate register.
  localparam logic [ID_W-1:0] c_ptr_init = ID_W'(NUM_REQ - 1);

  state_t                r_state;
  logic [ID_W-1:0]       r_last_grant;

  logic [NUM_REQ-1:0]    w_arb_grant;
  logic [ID_W-1:0]       w_arb_id;
  logic                  w_arb_found;
  logic [NUM_REQ-1:0]    w_ready;
  logic [NUM_REQ-1:0]    w_take;
  logic                  w_accept;
  logic [c_byte_w-1:0]   w_sel_data;
  logic                  w_sel_last;

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int                c_to_w    = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(BUSY_TIMEOUT - 1);
  localparam logic [c_to_w-1:0] c_to_one  = c_to_w'(1);
  logic [c_to_w-1:0]            r_to_cnt;
`endif

  uart_tx_sched_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .grant      (w_arb_grant),
    .grant_id   (w_arb_id),
    .found      (w_arb_found)
  );

  // Ready is offered only while selecting or locked, and never during reset
  always_comb begin
    w_ready = '0;
    if (rst_n) begin
      case (r_state)
        S_SELECT: begin
          if (w_arb_found) begin
            w_ready = w_arb_grant;
          end
        end
        S_LOCKED: begin
          for (int i = 0; i < NUM_REQ; i++) begin
            w_ready[i] = (grant_id == ID_W'(i));
          end
        end
        default: w_ready = '0;
      endcase
    end
  end

  assign req_ready = w_ready;
  assign w_take    = w_ready & req_valid;
  assign w_accept  = |w_take;

  // Mux the accepted requester's byte and last flag (at most one take bit set)
  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_take[i]) begin
        w_sel_data = req_data[c_byte_w*i +: c_byte_w];
        w_sel_last = req_last[i];
      end
    end
  end

  // Sequencer: accept, pulse enable, wait busy rise, wait busy fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_SELECT;
      r_last_grant <= c_ptr_init;
      grant_id     <= '0;
      active       <= 1'b0;
      tx_en        <= 1'b0;
      tx_data      <= '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      err_timeout  <= 1'b0;
      r_to_cnt     <= '0;
`endif
    end else begin
      tx_en <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      err_timeout <= 1'b0;
`endif
      case (r_state)
        S_SELECT: begin
          if (w_accept) begin
            grant_id     <= w_arb_id;
            r_last_grant <= w_arb_id;
            active       <= ~w_sel_last;
            tx_data      <= w_sel_data;
            tx_en        <= 1'b1;
            r_state      <= S_LOAD;
          end
        end
        S_LOCKED: begin
          if (w_accept) begin
            active  <= ~w_sel_last;
            tx_data <= w_sel_data;
            tx_en   <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_state <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (tx_busy) begin
            r_state <= S_WAIT_DONE;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            r_to_cnt <= '0;
          end else if (r_to_cnt == c_to_last) begin
            // Engine never started: drop the byte and release the lock
            err_timeout <= 1'b1;
            active      <= 1'b0;
            r_state     <= S_SELECT;
            r_to_cnt    <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + c_to_one;
`endif
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            r_state <= active ? S_LOCKED : S_SELECT;
          end
        end
        default: begin
          r_state <= S_SELECT;
        end
      endcase
    end
  end

`ifndef UART_TX_SCHED_TIMEOUT_EN
  assign err_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_sched
// Description : Randomized self-checking bench for uart_tx_sched. Producers
//               hold queued packets; a packet-level round-robin model gives
//               the expected byte order. Directed mid-op reset and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

  localparam int N    = 2;
  localparam int IDW  = 1;
  localparam int TO   = 64;
  localparam int MAXB = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*8-1:0]   req_data;
  logic [N-1:0]     req_last;
  logic [N-1:0]     req_ready;
  logic             tx_en;
  logic [7:0]       tx_data;
  logic             tx_busy;
  logic [IDW-1:0]   grant_id;
  logic             active;
  logic             err_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem_b [N][MAXB];
  logic       mem_l [N][MAXB];
  int         wr [N];
  int         rd [N];
  bit         mid [N];
  int         exp_req [N*MAXB];
  logic [7:0] exp_b [N*MAXB];
  logic       exp_l [N*MAXB];
  int         exp_n;
  int         exp_rd;

  always #5 clk = ~clk;

  uart_tx_sched #(
    .NUM_REQ      (N),
    .ID_W         (IDW),
    .BUSY_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_en       (tx_en),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .active      (active),
    .err_timeout (err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Fill producer queues with random packets and derive the expected order:
  // whole packets, taken round-robin over non-empty producers from requester 0
  task automatic build_round();
    int npk, len, ptr, idx;
    int pos [N];
    bit any;
    for (int i = 0; i < N; i++) begin
      wr[i] = 0; rd[i] = 0; mid[i] = 1'b0; pos[i] = 0;
      npk = $urandom_range(3, 5);
      for (int p = 0; p < npk; p++) begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          mem_b[i][wr[i]] = 8'($urandom);
          mem_l[i][wr[i]] = (b == len - 1);
          wr[i]++;
        end
      end
    end
    exp_n = 0; exp_rd = 0; ptr = N - 1;
    do begin
      any = 1'b0;
      for (int k = 1; k <= N && !any; k++) begin
        idx = (ptr + k) % N;
        if (pos[idx] < wr[idx]) begin
          any = 1'b1; ptr = idx;
          do begin
            exp_req[exp_n] = idx;
            exp_b[exp_n]   = mem_b[idx][pos[idx]];
            exp_l[exp_n]   = mem_l[idx][pos[idx]];
            exp_n++; pos[idx]++;
          end while (!exp_l[exp_n-1]);
        end
      end
    end while (any);
  endtask

  // Present each producer's head byte; mid-packet producers may stall randomly
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rd[i] < wr[i]) begin
        req_data[8*i +: 8] = mem_b[i][rd[i]];
        req_last[i]        = mem_l[i][rd[i]];
        req_valid[i]       = !(mid[i] && ($urandom_range(0, 3) == 0));
      end else begin
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
        req_valid[i]       = 1'b0;
      end
    end
  endtask

  task automatic run_round();
    int pop_req, budget, bph, bdly, blen, a;
    bit pend, inflight;
    logic [7:0] e_txd;
    logic [IDW-1:0] e_gid;
    logic e_act;
    logic [N-1:0] acc;
    build_round();
    rst_n = 1'b0; tx_busy = 1'b0;
    req_valid = '1; req_data = 16'hC35A; req_last = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_active", active, 0);
    check("rst_err_timeout", err_timeout, 0);
    pop_req = -1; budget = 0; bph = 0; bdly = 0; blen = 0;
    pend = 1'b0; inflight = 1'b0;
    e_txd = '0; e_gid = '0; e_act = 1'b0;
    drive();
    rst_n = 1'b1;
    while (!(exp_rd == exp_n && bph == 0 && !pend) && budget < 4000) begin
      #1;
      acc = req_valid & req_ready;
      if (acc != 0) begin
        a = 0;
        for (int i = 0; i < N; i++) if (acc[i]) a = i;
        check("accept_onehot", $countones(acc), 1);
        check("accept_engine_idle", inflight, 0);
        if (exp_rd < exp_n) begin
          check("accept_req", a, exp_req[exp_rd]);
          check("accept_byte", req_data[8*a +: 8], exp_b[exp_rd]);
          exp_rd++;
        end else begin
          check("accept_extra", acc, 0);
        end
        e_txd = req_data[8*a +: 8];
        e_gid = a[IDW-1:0];
        e_act = !req_last[a];
        pend = 1'b1; inflight = 1'b1; pop_req = a;
      end
      @(negedge clk);
      budget++;
      check("tx_en", tx_en, pend);
      pend = 1'b0;
      check("tx_data", tx_data, e_txd);
      check("grant_id", grant_id, e_gid);
      check("active", active, e_act);
      check("err_timeout", err_timeout, 0);
      if ($countones(req_ready) > 1) check("ready_onehot", $countones(req_ready), 1);
      // Send-engine model: busy rises 0..3 cycles after the pulse, holds 1..6
      if (tx_en) begin
        bdly = $urandom_range(0, 3); blen = $urandom_range(1, 6); bph = 1;
      end
      if (bph == 1) begin
        if (bdly == 0) begin tx_busy = 1'b1; bph = 2; end
        else bdly--;
      end else if (bph == 2) begin
        if (blen == 0) begin tx_busy = 1'b0; bph = 0; inflight = 1'b0; end
        else blen--;
      end
      if (pop_req >= 0) begin
        mid[pop_req] = !mem_l[pop_req][rd[pop_req]];
        rd[pop_req]++;
        pop_req = -1;
      end
      drive();
    end
    check("round_done", exp_rd, exp_n);
  endtask

  task automatic test_midop_reset();
    rst_n = 1'b0; tx_busy = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b10; req_data[15:8] = 8'hA5; req_last = 2'b10;
    #1;
    check("single_ready", req_ready, 2'b10);
    @(negedge clk);
    req_valid = 2'b01; req_data[7:0] = 8'h5E; req_last = 2'b00;
    check("single_tx_en", tx_en, 1);
    check("single_tx_data", tx_data, 8'hA5);
    check("single_grant", grant_id, 1);
    check("single_active", active, 0);
    tx_busy = 1'b1;
    @(negedge clk);
    check("single_pulse_width", tx_en, 0);
    @(negedge clk);
    check("wait_done_ready", req_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx_data", tx_data, 0);
    check("midrst_grant", grant_id, 0);
    check("midrst_active", active, 0);
    check("midrst_tx_en", tx_en, 0);
    check("midrst_ready", req_ready, 0);
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_tx_en", tx_en, 0);
    end
    tx_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_select_ready", req_ready, 2'b01);
  endtask

  task automatic test_timeout();
    rst_n = 1'b0; tx_busy = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b01; req_data[7:0] = 8'h3C; req_last = 2'b00;
    @(negedge clk);
    req_valid = 2'b11; req_data = 16'h7744; req_last = 2'b11;
    check("to_tx_en", tx_en, 1);
    check("to_active", active, 1);
`ifdef UART_TX_SCHED_TIMEOUT_EN
    begin
      int k;
      k = 0;
      while (!err_timeout && k < 200) begin
        @(negedge clk);
        k++;
      end
      check("to_latency", k, TO + 1);
      check("to_active_clr", active, 0);
      check("to_ready_release", req_ready, 2'b10);
      @(negedge clk);
      check("to_pulse_once", err_timeout, 0);
      check("to_next_tx_en", tx_en, 1);
      check("to_next_data", tx_data, 8'h77);
    end
`else
    begin
      int seen;
      seen = 0;
      repeat (100) begin
        @(negedge clk);
        if (err_timeout) seen++;
        if (tx_en) seen++;
      end
      check("to_never", seen, 0);
      check("to_stalled_ready", req_ready, 0);
      check("to_active_held", active, 1);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0; tx_busy = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
    for (int r = 0; r < 3; r++) run_round();
    test_midop_reset();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
`default_nettype wire
